// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared command codes and arbiter source indices for tetris_cmd_gen
// Purpose: command encoding seen by the game-logic FSM and the arbiter source order.
// Ports: none (package).
package tetris_pkg;

    typedef enum logic [2:0] {
        CMD_ROT   = 3'd0,
        CMD_LEFT  = 3'd1,
        CMD_RIGHT = 3'd2,
        CMD_SOFT  = 3'd3,
        CMD_GRAV  = 3'd4
    } cmd_t;

    // Source index doubles as arbitration priority: lower index wins.
    localparam int NUM_SRC   = 5;
    localparam int SRC_ROT   = 0;
    localparam int SRC_LEFT  = 1;
    localparam int SRC_RIGHT = 2;
    localparam int SRC_SOFT  = 3;
    localparam int SRC_GRAV  = 4;

    function automatic cmd_t src_to_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    return CMD_ROT;
            3'd1:    return CMD_LEFT;
            3'd2:    return CMD_RIGHT;
            3'd3:    return CMD_SOFT;
            default: return CMD_GRAV;
        endcase
    endfunction

endpackage

// File: rtl/tetris_cmd_gen_auto_repeat.sv
// rtl/tetris_cmd_gen_auto_repeat.sv - DAS/ARR auto-repeat for one held key
// Purpose: one event per press, a first repeat after DAS_DELAY cycles of holding,
//          then one event every ARR_PERIOD cycles until the key is released.
// Ports: clk, rst (sync active-high), press_p (one-cycle press pulse),
//        level (key held), evt (combinational one-cycle event).
module auto_repeat #(
    parameter int DAS_DELAY  = 15000000,
    parameter int ARR_PERIOD = 5000000,
    parameter int CNT_W      = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic press_p,
    input  logic level,
    output logic evt
);

    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_DELAY - 1);
    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    rep_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        evt     = 1'b0;
        // A fresh press always wins: it emits and restarts the DAS delay
        // regardless of where the repeater currently is.
        if (press_p) begin
            evt     = 1'b1;
            cnt_n   = '0;
            state_n = DELAY;
        end else begin
            case (state)
                DELAY: begin
                    if (!level) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt == DAS_LAST) begin
                        evt     = 1'b1;
                        cnt_n   = '0;
                        state_n = REPEAT;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!level) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt == ARR_LAST) begin
                        evt   = 1'b1;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/tetris_cmd_gen.sv
// rtl/tetris_cmd_gen.sv - key/gravity move-event generator with command FIFO
// Purpose: turns debounced key pulses/levels and a gravity timer into move
//          commands, merges duplicates in per-source pending flags, and
//          queues them by priority into a small FIFO for the game logic.
// Ports: clk, rst (sync active-high); u_p/d_p/l_p/r_p press pulses;
//        u_lv/d_lv/l_lv/r_lv held levels; grav_en; cmd_valid/cmd/cmd_ready
//        command handshake; drop_cnt saturating count of merged events.
module tetris_cmd_gen
    import tetris_pkg::*;
#(
    parameter int DAS_DELAY   = 15000000,
    parameter int ARR_PERIOD  = 5000000,
    parameter int GRAV_PERIOD = 50000000,
    parameter int CNT_W       = 26,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       u_p,
    input  logic       d_p,
    input  logic       l_p,
    input  logic       r_p,
    input  logic       u_lv,
    input  logic       d_lv,
    input  logic       l_lv,
    input  logic       r_lv,
    input  logic       grav_en,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    input  logic       cmd_ready,
    output logic [7:0] drop_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] GRAV_LAST = CNT_W'(GRAV_PERIOD - 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    logic               evt_l, evt_r, evt_d, grav_evt;
    logic [NUM_SRC-1:0] ev, pend, clr, merged;
    logic               sel_valid, push, pop, soft_enq;
    logic [2:0]         sel_idx;
    logic [2:0]         n_drop;
    logic [8:0]         drop_sum;
    logic [CNT_W-1:0]   grav_cnt;

    cmd_t               mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;

    // Up has no held behaviour, so u_lv is deliberately unused.
    logic unused_ok;
    assign unused_ok = u_lv;

    auto_repeat #(.DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .CNT_W(CNT_W)) u_rep_l (
        .clk(clk), .rst(rst), .press_p(l_p), .level(l_lv), .evt(evt_l)
    );
    auto_repeat #(.DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .CNT_W(CNT_W)) u_rep_r (
        .clk(clk), .rst(rst), .press_p(r_p), .level(r_lv), .evt(evt_r)
    );
    auto_repeat #(.DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .CNT_W(CNT_W)) u_rep_d (
        .clk(clk), .rst(rst), .press_p(d_p), .level(d_lv), .evt(evt_d)
    );

    assign grav_evt = grav_en && (grav_cnt == GRAV_LAST);
    assign ev       = {grav_evt, evt_d, evt_r, evt_l, u_p};

    // Priority pick: scanning downward leaves the lowest pending index selected.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_valid = 1'b1;
                sel_idx   = 3'(i);
            end
        end
    end

    assign cmd_valid = (count != '0);
    assign pop       = cmd_valid && cmd_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push      = sel_valid && ((count != FULL_CNT) || pop);
    assign clr       = push ? (NUM_SRC'(1) << sel_idx) : '0;
    assign soft_enq  = push && (sel_idx == 3'(SRC_SOFT));

    // An event on a flag that is being cleared this cycle just re-arms it;
    // only events landing on a flag that stays set are lost.
    assign merged = ev & pend & ~clr;

    always_comb begin
        n_drop = 3'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            n_drop = n_drop + {2'b00, merged[i]};
        end
        drop_sum = {1'b0, drop_cnt} + {6'd0, n_drop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            drop_cnt <= '0;
            grav_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            pend     <= ev | (pend & ~clr);
            drop_cnt <= drop_sum[8] ? 8'hff : drop_sum[7:0];
            if (!grav_en || soft_enq || grav_evt) begin
                grav_cnt <= '0;
            end else begin
                grav_cnt <= grav_cnt + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: cmd is gated by cmd_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= src_to_cmd(sel_idx);
        end
    end

    assign cmd = cmd_valid ? mem[rd_ptr] : CMD_ROT;

endmodule
